pixel_frame_sequencer: RTL and testbench
========================================

Name: pixel_frame_sequencer

Overview:
Parametrised second-generation frame sequencer for the digital pixel sensor array. It drives erase, expose, ramp-convert and row-by-row readout phases, with runtime-programmable erase and expose durations, single-shot or continuous framing, and a start/busy/done handshake. It replaces the fixed-duration single-row sequencer and sits between the top-level controller and the pixel array plus readout bus. All outputs are registered; no gated or analog outputs.

Parameters:
WIDTH, 4, pixels per row
HEIGHT, 4, rows in the array (≥1)
OUTPUT_BUS_PIXEL_WIDTH, 2, pixels transferred per read strobe; WORDS_PER_ROW = ceil(WIDTH/OUTPUT_BUS_PIXEL_WIDTH)
BIT_DEPTH, 8, ramp/counter resolution; convert phase lasts 2^BIT_DEPTH cycles
DUR_W, 16, width of programmable duration inputs

Ports:
SYSTEM_CLK  in  1  system clock, all logic on rising edge
SYSTEM_RESET_N  in  1  asynchronous, active-low reset
START  in  1  one-cycle frame request, honoured only in IDLE
ABORT  in  1  synchronous abort, returns to IDLE
CONTINUOUS  in  1  1 = start next frame automatically after READ
ERASE_CYCLES  in  DUR_W  erase duration, latched on accepted START
EXPOSE_CYCLES  in  DUR_W  expose duration, latched on accepted START
POWER_ENABLE  out  1  comparator power, high in EXPOSE/CONVERT/READ
WRITE_ENABLE  out  1  pixel memory write enable, high in EXPOSE/CONVERT
COUNTER_RESET  out  1  high in ERASE
COUNTER_STEP  out  1  one strobe per ramp step, high every CONVERT cycle
RAMP_CODE  out  BIT_DEPTH  digital ramp value
ERASE  out  1  pixel reset, high in ERASE
EXPOSE  out  1  photogate, high in EXPOSE
READ_RESET  out  1  one-cycle pulse at start of each row read
READ_CLK_IN  out  1  one-cycle strobe per output word
READ_ROW  out  $clog2(HEIGHT) (min 1)  row currently being read
BUSY  out  1  high in every state except IDLE
FRAME_DONE  out  1  one-cycle pulse on completion of last read word

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; every output 0; RAMP_CODE 0; READ_ROW 0; latched durations 0.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ. No IDLE gaps between phases; each transition takes effect on the edge after the last cycle of the phase.
- IDLE: START=1 latches ERASE_CYCLES/EXPOSE_CYCLES and enters ERASE next cycle. START in any other state is ignored.
- ERASE: lasts max(ERASE_CYCLES,1) cycles, then EXPOSE.
- EXPOSE: lasts max(EXPOSE_CYCLES,1) cycles, then CONVERT. A zero duration is treated as 1.
- CONVERT: exactly 2^BIT_DEPTH cycles. RAMP_CODE = 0,1,…,2^BIT_DEPTH−1, one step per cycle. COUNTER_STEP is high on each of these cycles. RAMP_CODE returns to 0 on exit to READ.
- READ: for row r = 0…HEIGHT−1, READ_ROW=r:
  - 1 cycle with READ_RESET=1,
  - then WORDS_PER_ROW cycles with READ_CLK_IN=1.
  - Row time is 1+WORDS_PER_ROW cycles; total READ = HEIGHT·(1+WORDS_PER_ROW) cycles.
- End of READ: FRAME_DONE pulses on the cycle after the final READ_CLK_IN cycle.
  - CONTINUOUS=1 (sampled on the last READ cycle): ERASE next, using the durations latched at the original START. Durations are not re-latched.
  - CONTINUOUS=0: IDLE.
- ABORT=1 in any state: IDLE next cycle, all outputs 0, no FRAME_DONE. ABORT has priority over START when both are asserted in IDLE (stay IDLE).
- Counters: one phase counter of max(DUR_W, BIT_DEPTH+1, row-count width) bits, cleared on every state change. No wrap is possible within any phase.
- Frame latency from START to the first FRAME_DONE = 1 + E + X + 2^BIT_DEPTH + HEIGHT·(1+WORDS_PER_ROW) cycles. E and X are the clamped durations.

Optional Feature:
CDS_SAMPLE_EN:
- Defined: a CONVERT_RST phase of 2^BIT_DEPTH cycles is inserted between ERASE and EXPOSE, behaving exactly as CONVERT (ramp, COUNTER_STEP, POWER_ENABLE, WRITE_ENABLE). Extra output CDS_PHASE is 1 during CONVERT_RST only. Frame latency grows by 2^BIT_DEPTH.
- Undefined: no CONVERT_RST state and no CDS_PHASE port.

Test Plan:
1. Reset mid-CONVERT (SYSTEM_RESET_N low at RAMP_CODE=100) -> all outputs 0 immediately, state IDLE, START afterwards runs a normal frame.
2. Defaults, ERASE_CYCLES=5, EXPOSE_CYCLES=10, CONTINUOUS=0, START pulse -> ERASE high 5 cycles, EXPOSE 10, RAMP_CODE 0..255 over 256 cycles, 4 rows each 1 READ_RESET + 2 READ_CLK_IN, FRAME_DONE at cycle 1+5+10+256+12=284, then IDLE with BUSY=0.
3. ERASE_CYCLES=0, EXPOSE_CYCLES=0 -> each phase lasts exactly 1 cycle.
4. CONTINUOUS=1, change ERASE_CYCLES to 9 after START -> second frame still uses 5 erase cycles; FRAME_DONE pulses every 283 cycles with no IDLE gap.
5. ABORT in READ row 2 -> IDLE next cycle, no FRAME_DONE; START during EXPOSE ignored; START+ABORT in IDLE -> remains IDLE.
6. WIDTH=5, OUTPUT_BUS_PIXEL_WIDTH=2, HEIGHT=3 -> 3 READ_CLK_IN strobes per row, READ_ROW 0,1,2. With CDS_SAMPLE_EN defined -> CDS_PHASE high 256 cycles between ERASE and EXPOSE.

Source files
------------

// File: rtl/pixel_frame_sequencer.sv
`default_nettype none
// ============================================================================
// pixel_frame_sequencer
// Erase / expose / ramp-convert / row-readout frame sequencer for the pixel array.
// Optional feature macro: CDS_SAMPLE_EN adds a reset-level CONVERT_RST ramp phase.
// Revision: 1.0
// ============================================================================
module pixel_frame_sequencer #(
  parameter int WIDTH                  = 4,
  parameter int HEIGHT                 = 4,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  parameter int DUR_W                  = 16
) (
  input  logic                                         SYSTEM_CLK,
  input  logic                                         SYSTEM_RESET_N,
  input  logic                                         START,
  input  logic                                         ABORT,
  input  logic                                         CONTINUOUS,
  input  logic [DUR_W-1:0]                             ERASE_CYCLES,
  input  logic [DUR_W-1:0]                             EXPOSE_CYCLES,
  output logic                                         POWER_ENABLE,
  output logic                                         WRITE_ENABLE,
  output logic                                         COUNTER_RESET,
  output logic                                         COUNTER_STEP,
  output logic [BIT_DEPTH-1:0]                         RAMP_CODE,
  output logic                                         ERASE,
  output logic                                         EXPOSE,
  output logic                                         READ_RESET,
  output logic                                         READ_CLK_IN,
  output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] READ_ROW,
  output logic                                         BUSY,
  output logic                                         FRAME_DONE
`ifdef CDS_SAMPLE_EN
  ,
  output logic                                         CDS_PHASE
`endif
);

  localparam int ROW_W         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int WORDS_PER_ROW = (WIDTH + OUTPUT_BUS_PIXEL_WIDTH - 1) / OUTPUT_BUS_PIXEL_WIDTH;
  localparam int WORD_W        = $clog2(WORDS_PER_ROW + 1);
  localparam int CW0           = (DUR_W > BIT_DEPTH + 1) ? DUR_W : BIT_DEPTH + 1;
  localparam int CW1           = (CW0 > ROW_W) ? CW0 : ROW_W;
  localparam int CNT_W         = (CW1 > WORD_W) ? CW1 : WORD_W;

  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'((2 ** BIT_DEPTH) - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORDS_PER_ROW);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_CONVERT_RST, S_EXPOSE, S_CONVERT, S_READ
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DUR_W-1:0]   erase_q, expose_q;
  logic               done_d;

  logic [DUR_W-1:0]   w_erase_len, w_expose_len;
  logic               w_erase_last, w_expose_last, w_ramp_last, w_ramp_d;

  // A programmed duration of zero behaves as a single cycle.
  assign w_erase_len   = (erase_q  == '0) ? DUR_W'(1) : erase_q;
  assign w_expose_len  = (expose_q == '0) ? DUR_W'(1) : expose_q;
  assign w_erase_last  = (cnt_q + CNT_W'(1)) == CNT_W'(w_erase_len);
  assign w_expose_last = (cnt_q + CNT_W'(1)) == CNT_W'(w_expose_len);
  assign w_ramp_last   = (cnt_q == RAMP_LAST);

`ifdef CDS_SAMPLE_EN
  assign w_ramp_d = (state_d == S_CONVERT) || (state_d == S_CONVERT_RST);
`else
  assign w_ramp_d = (state_d == S_CONVERT);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    done_d  = 1'b0;
    if (ABORT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_ERASE;
            cnt_d   = '0;
          end
        end
        S_ERASE: begin
          if (w_erase_last) begin
`ifdef CDS_SAMPLE_EN
            state_d = S_CONVERT_RST;
`else
            state_d = S_EXPOSE;
`endif
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef CDS_SAMPLE_EN
        S_CONVERT_RST: begin
          if (w_ramp_last) begin
            state_d = S_EXPOSE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        S_EXPOSE: begin
          if (w_expose_last) begin
            state_d = S_CONVERT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_CONVERT: begin
          if (w_ramp_last) begin
            state_d = S_READ;
            cnt_d   = '0;
            row_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_READ: begin
          // Within a row: count 0 is the row reset, 1..WORDS_PER_ROW are word strobes.
          if (cnt_q == WORD_LAST) begin
            cnt_d = '0;
            if (row_q == ROW_LAST) begin
              done_d  = 1'b1;
              row_d   = '0;
              state_d = CONTINUOUS ? S_ERASE : S_IDLE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          row_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state view so they align with the state.
  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      erase_q       <= '0;
      expose_q      <= '0;
      POWER_ENABLE  <= 1'b0;
      WRITE_ENABLE  <= 1'b0;
      COUNTER_RESET <= 1'b0;
      COUNTER_STEP  <= 1'b0;
      RAMP_CODE     <= '0;
      ERASE         <= 1'b0;
      EXPOSE        <= 1'b0;
      READ_RESET    <= 1'b0;
      READ_CLK_IN   <= 1'b0;
      READ_ROW      <= '0;
      BUSY          <= 1'b0;
      FRAME_DONE    <= 1'b0;
`ifdef CDS_SAMPLE_EN
      CDS_PHASE     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      if ((state_q == S_IDLE) && START && !ABORT) begin
        erase_q  <= ERASE_CYCLES;
        expose_q <= EXPOSE_CYCLES;
      end
      POWER_ENABLE  <= (state_d == S_EXPOSE) || w_ramp_d || (state_d == S_READ);
      WRITE_ENABLE  <= (state_d == S_EXPOSE) || w_ramp_d;
      COUNTER_RESET <= (state_d == S_ERASE);
      COUNTER_STEP  <= w_ramp_d;
      RAMP_CODE     <= w_ramp_d ? cnt_d[BIT_DEPTH-1:0] : '0;
      ERASE         <= (state_d == S_ERASE);
      EXPOSE        <= (state_d == S_EXPOSE);
      READ_RESET    <= (state_d == S_READ) && (cnt_d == '0);
      READ_CLK_IN   <= (state_d == S_READ) && (cnt_d != '0);
      READ_ROW      <= (state_d == S_READ) ? row_d : '0;
      BUSY          <= (state_d != S_IDLE);
      FRAME_DONE    <= done_d;
`ifdef CDS_SAMPLE_EN
      CDS_PHASE     <= (state_d == S_CONVERT_RST);
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_sequencer.sv
`default_nettype none
// Bench for pixel_frame_sequencer: DUT traces compared cycle-by-cycle with a
// phase-list model built from durations, row count and words per row.
module tb_pixel_frame_sequencer;

  localparam int RAMP_N = 256;
`ifdef CDS_SAMPLE_EN
  localparam int CDS_N = RAMP_N;
`else
  localparam int CDS_N = 0;
`endif

  typedef struct packed {
    logic       pe, we, cr, cs;
    logic [7:0] ramp;
    logic       er, ex, rr, rc;
    logic [1:0] row;
    logic       busy, done, cds;
  } obs_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        START = 1'b0, ABORT = 1'b0, CONTINUOUS = 1'b0;
  logic [15:0] ERASE_CYCLES = '0, EXPOSE_CYCLES = '0;

  logic       a_pe, a_we, a_cr, a_cs, a_er, a_ex, a_rr, a_rc, a_busy, a_done, a_cds;
  logic [7:0] a_ramp;
  logic [1:0] a_row;
  logic       b_pe, b_we, b_cr, b_cs, b_er, b_ex, b_rr, b_rc, b_busy, b_done, b_cds;
  logic [7:0] b_ramp;
  logic [1:0] b_row;

  int   n_tests = 0, n_fail = 0;
  obs_t q[$];

  always #5 clk = ~clk;

  pixel_frame_sequencer dut (
    .SYSTEM_CLK(clk), .SYSTEM_RESET_N(rst_n), .START(START), .ABORT(ABORT),
    .CONTINUOUS(CONTINUOUS), .ERASE_CYCLES(ERASE_CYCLES), .EXPOSE_CYCLES(EXPOSE_CYCLES),
    .POWER_ENABLE(a_pe), .WRITE_ENABLE(a_we), .COUNTER_RESET(a_cr), .COUNTER_STEP(a_cs),
    .RAMP_CODE(a_ramp), .ERASE(a_er), .EXPOSE(a_ex), .READ_RESET(a_rr), .READ_CLK_IN(a_rc),
    .READ_ROW(a_row), .BUSY(a_busy), .FRAME_DONE(a_done)
`ifdef CDS_SAMPLE_EN
    , .CDS_PHASE(a_cds)
`endif
  );

  pixel_frame_sequencer #(.WIDTH(5), .HEIGHT(3), .OUTPUT_BUS_PIXEL_WIDTH(2)) dut_wide (
    .SYSTEM_CLK(clk), .SYSTEM_RESET_N(rst_n), .START(START), .ABORT(ABORT),
    .CONTINUOUS(CONTINUOUS), .ERASE_CYCLES(ERASE_CYCLES), .EXPOSE_CYCLES(EXPOSE_CYCLES),
    .POWER_ENABLE(b_pe), .WRITE_ENABLE(b_we), .COUNTER_RESET(b_cr), .COUNTER_STEP(b_cs),
    .RAMP_CODE(b_ramp), .ERASE(b_er), .EXPOSE(b_ex), .READ_RESET(b_rr), .READ_CLK_IN(b_rc),
    .READ_ROW(b_row), .BUSY(b_busy), .FRAME_DONE(b_done)
`ifdef CDS_SAMPLE_EN
    , .CDS_PHASE(b_cds)
`endif
  );

`ifndef CDS_SAMPLE_EN
  assign a_cds = 1'b0;
  assign b_cds = 1'b0;
`endif

  function automatic obs_t sample_a();
    obs_t o;
    o.pe = a_pe; o.we = a_we; o.cr = a_cr; o.cs = a_cs; o.ramp = a_ramp;
    o.er = a_er; o.ex = a_ex; o.rr = a_rr; o.rc = a_rc; o.row = a_row;
    o.busy = a_busy; o.done = a_done; o.cds = a_cds;
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.pe = b_pe; o.we = b_we; o.cr = b_cr; o.cs = b_cs; o.ramp = b_ramp;
    o.er = b_er; o.ex = b_ex; o.rr = b_rr; o.rc = b_rc; o.row = b_row;
    o.busy = b_busy; o.done = b_done; o.cds = b_cds;
    return o;
  endfunction

  // Reference model: one frame as a list of phases, each a run of identical cycles.
  function automatic void build_frame(input int e, input int x, input int h, input int wpr);
    obs_t o;
    int   ee, xx;
    ee = (e == 0) ? 1 : e;
    xx = (x == 0) ? 1 : x;
    for (int i = 0; i < ee; i++) begin
      o = '0; o.cr = 1'b1; o.er = 1'b1; o.busy = 1'b1; q.push_back(o);
    end
    for (int i = 0; i < CDS_N; i++) begin
      o = '0; o.pe = 1'b1; o.we = 1'b1; o.cs = 1'b1; o.cds = 1'b1; o.busy = 1'b1;
      o.ramp = 8'(i); q.push_back(o);
    end
    for (int i = 0; i < xx; i++) begin
      o = '0; o.pe = 1'b1; o.we = 1'b1; o.ex = 1'b1; o.busy = 1'b1; q.push_back(o);
    end
    for (int i = 0; i < RAMP_N; i++) begin
      o = '0; o.pe = 1'b1; o.we = 1'b1; o.cs = 1'b1; o.busy = 1'b1;
      o.ramp = 8'(i); q.push_back(o);
    end
    for (int r = 0; r < h; r++) begin
      for (int w = 0; w <= wpr; w++) begin
        o = '0; o.pe = 1'b1; o.busy = 1'b1; o.row = 2'(r);
        o.rr = (w == 0); o.rc = (w != 0); q.push_back(o);
      end
    end
  endfunction

  function automatic void push_idle(input bit done);
    obs_t o;
    o = '0; o.done = done; q.push_back(o);
  endfunction

  task automatic start_frame(input int e, input int x, input bit c);
    @(negedge clk);
    ERASE_CYCLES = 16'(e); EXPOSE_CYCLES = 16'(x); CONTINUOUS = c; START = 1'b1;
  endtask

  task automatic go_idle();
    @(negedge clk); START = 1'b0; ABORT = 1'b1;
    @(negedge clk); ABORT = 1'b0; CONTINUOUS = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    o = sample_a();
    n_tests++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", o); end
    o = sample_b();
    n_tests++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_outputs_wide: got %h want 0", o); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_convert();
    obs_t o, fo, fw;
    int   found, errs, fi;
    start_frame(2, 2, 1'b0);
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      @(negedge clk); START = 1'b0;
      if (a_cs === 1'b1 && a_ramp === 8'd100) found = 1;
    end
    n_tests++;
    if (found == 0) begin n_fail++; $display("FAIL mid_convert_wait: ramp 100 never seen, got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1 o = sample_a();
    n_tests++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_async: got %h want 0", o); end
    @(negedge clk); rst_n = 1'b1;
    q.delete(); build_frame(1, 1, 4, 2); push_idle(1'b1);
    start_frame(1, 1, 1'b0);
    errs = 0; fi = 0; fo = '0; fw = '0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk); START = 1'b0; o = sample_a();
      if (o !== q[i]) begin if (errs == 0) begin fi = i; fo = o; fw = q[i]; end errs++; end
    end
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL frame_after_reset: %0d cycles, first cycle %0d got %h want %h", errs, fi + 1, fo, fw); end
  endtask

  task automatic test_default_frame();
    obs_t o, fo, fw;
    int   errs, fi, done_at;
    q.delete(); build_frame(5, 10, 4, 2); push_idle(1'b1);
    for (int i = 0; i < 4; i++) push_idle(1'b0);
    start_frame(5, 10, 1'b0);
    errs = 0; fi = 0; fo = '0; fw = '0; done_at = -1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk); START = 1'b0; o = sample_a();
      if (o.done === 1'b1 && done_at < 0) done_at = i + 1;
      if (o !== q[i]) begin if (errs == 0) begin fi = i; fo = o; fw = q[i]; end errs++; end
    end
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL default_frame: %0d cycles, first cycle %0d got %h want %h", errs, fi + 1, fo, fw); end
    n_tests++;
    if (done_at != 1 + 5 + 10 + CDS_N + RAMP_N + 12) begin
      n_fail++; $display("FAIL default_latency: got %0d want %0d", done_at, 1 + 5 + 10 + CDS_N + RAMP_N + 12);
    end
    n_tests++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_frame: busy got %b want 0", a_busy); end
  endtask

  task automatic test_zero_durations();
    obs_t o, fo, fw;
    int   errs, fi;
    q.delete(); build_frame(0, 0, 4, 2); push_idle(1'b1);
    start_frame(0, 0, 1'b0);
    errs = 0; fi = 0; fo = '0; fw = '0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk); START = 1'b0; o = sample_a();
      if (o !== q[i]) begin if (errs == 0) begin fi = i; fo = o; fw = q[i]; end errs++; end
    end
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL zero_durations: %0d cycles, first cycle %0d got %h want %h", errs, fi + 1, fo, fw); end
  endtask

  task automatic test_continuous();
    obs_t o, fo, fw;
    int   errs, fi, n1, d1, d2;
    q.delete(); build_frame(5, 10, 4, 2);
    n1 = q.size();
    build_frame(5, 10, 4, 2);
    q[n1].done = 1'b1;
    push_idle(1'b1);
    start_frame(5, 10, 1'b1);
    errs = 0; fi = 0; fo = '0; fw = '0; d1 = -1; d2 = -1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk); o = sample_a();
      START = 1'b0; ERASE_CYCLES = 16'd9; EXPOSE_CYCLES = 16'd3;
      if (i == n1 + 50) CONTINUOUS = 1'b0;
      if (o.done === 1'b1) begin if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i; end
      if (o !== q[i]) begin if (errs == 0) begin fi = i; fo = o; fw = q[i]; end errs++; end
    end
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL continuous: %0d cycles, first cycle %0d got %h want %h", errs, fi + 1, fo, fw); end
    n_tests++;
    if (d2 - d1 != 5 + 10 + CDS_N + RAMP_N + 12) begin
      n_fail++; $display("FAIL continuous_period: got %0d want %0d", d2 - d1, 5 + 10 + CDS_N + RAMP_N + 12);
    end
  endtask

  task automatic test_abort();
    obs_t o, fo, fw;
    int   errs, fi, abort_at, dones, busy_seen;
    q.delete(); build_frame(3, 20, 4, 2);
    abort_at = 3 + CDS_N + 20 + RAMP_N + 2 * 3 + 1;
    start_frame(3, 20, 1'b0);
    errs = 0; fi = 0; fo = '0; fw = '0;
    for (int i = 0; i <= abort_at; i++) begin
      @(negedge clk); o = sample_a();
      START = 1'b0;
      if (i == 5) begin START = 1'b1; ERASE_CYCLES = 16'd40; end
      if (i == abort_at) ABORT = 1'b1;
      if (o !== q[i]) begin if (errs == 0) begin fi = i; fo = o; fw = q[i]; end errs++; end
    end
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL start_ignored: %0d cycles, first cycle %0d got %h want %h", errs, fi + 1, fo, fw); end
    @(negedge clk); ABORT = 1'b0; o = sample_a();
    n_tests++;
    if (o !== '0) begin n_fail++; $display("FAIL abort_to_idle: got %h want 0", o); end
    dones = 0; busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_done !== 1'b0) dones++;
      if (a_busy !== 1'b0) busy_seen++;
    end
    n_tests++;
    if (dones + busy_seen != 0) begin n_fail++; $display("FAIL abort_no_done: done/busy cycles got %0d want 0", dones + busy_seen); end
    @(negedge clk); START = 1'b1; ABORT = 1'b1;
    @(negedge clk); START = 1'b0; ABORT = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sample_a() !== '0) busy_seen++;
    end
    n_tests++;
    if (busy_seen != 0) begin n_fail++; $display("FAIL start_abort_idle: non-idle cycles got %0d want 0", busy_seen); end
  endtask

  task automatic test_wide_frame();
    obs_t o, fo, fw;
    int   errs, fi, e, x;
    int   strobes[3];
    e = int'($urandom_range(0, 6));
    x = int'($urandom_range(0, 6));
    q.delete(); build_frame(e, x, 3, 3); push_idle(1'b1);
    start_frame(e, x, 1'b0);
    errs = 0; fi = 0; fo = '0; fw = '0;
    for (int r = 0; r < 3; r++) strobes[r] = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk); START = 1'b0; o = sample_b();
      if (o.rc === 1'b1 && o.row < 2'd3) strobes[o.row]++;
      if (o !== q[i]) begin if (errs == 0) begin fi = i; fo = o; fw = q[i]; end errs++; end
    end
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL wide_frame e=%0d x=%0d: %0d cycles, first cycle %0d got %h want %h", e, x, errs, fi + 1, fo, fw); end
    for (int r = 0; r < 3; r++) begin
      n_tests++;
      if (strobes[r] != 3) begin n_fail++; $display("FAIL wide_strobes row %0d: got %0d want 3", r, strobes[r]); end
    end
  endtask

  task automatic test_random_frames();
    obs_t o, fo, fw;
    int   errs, fi, e, x;
    for (int f = 0; f < 3; f++) begin
      e = int'($urandom_range(0, 20));
      x = int'($urandom_range(0, 20));
      q.delete(); build_frame(e, x, 4, 2); push_idle(1'b1);
      start_frame(e, x, 1'b0);
      errs = 0; fi = 0; fo = '0; fw = '0;
      for (int i = 0; i < q.size(); i++) begin
        @(negedge clk); START = 1'b0; o = sample_a();
        if (o !== q[i]) begin if (errs == 0) begin fi = i; fo = o; fw = q[i]; end errs++; end
      end
      n_tests++;
      if (errs != 0) begin n_fail++; $display("FAIL random_frame e=%0d x=%0d: %0d cycles, first cycle %0d got %h want %h", e, x, errs, fi + 1, fo, fw); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_convert();
    go_idle();
    test_default_frame();
    go_idle();
    test_zero_durations();
    go_idle();
    test_continuous();
    go_idle();
    test_abort();
    go_idle();
    test_wide_frame();
    go_idle();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
